// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter -- framebuffer memory arbiter for a VGA scan-out engine.
//
// A single-port framebuffer memory is shared between the video fetch path
// and a buffered writer. Video reads always win; buffered writes drain in
// push order on any edge with no video request.
//
// Ports
//   Clock50    : sole clock (rising edge)
//   Reset      : asynchronous active-low reset
//   VidReq     : video fetch request pulse, VidAddr sampled with it
//   VidValid   : one-cycle pulse, VidData carries the fetched word
//   WrReq      : push {WrAddr, WrData} into the write buffer
//   WrReady    : write buffer not full (registered, post-edge occupancy)
//   WrOverflow : sticky, push attempted while full
//   MemAddr    : memory address
//   MemWe      : memory write strobe
//   MemWData   : memory write data
//   MemRData   : memory read data, valid one cycle after a read issue
//   Idle       : buffer empty, no read in flight, arbiter idle
module vga_fb_arbiter #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              Clock50,
  input  logic              Reset,
  input  logic              VidReq,
  input  logic [ADDR_W-1:0] VidAddr,
  output logic              VidValid,
  output logic [DATA_W-1:0] VidData,
  input  logic              WrReq,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  output logic              WrReady,
  output logic              WrOverflow,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemWe,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  output logic              Idle
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  // vld_pipe_q[0]: read issued last edge; [1]: its data is on MemRData now
  logic [1:0]        vld_pipe_q;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];

  logic push, pop;
  logic wr_ready_d, idle_d;

  // A push is only taken against the registered WrReady; a request while
  // full is dropped even if a pop happens on the same edge, which keeps the
  // writer-visible handshake purely registered.
  assign push = WrReq & WrReady;
  // Pop only what was already buffered, so an entry pushed into an empty
  // FIFO is written on a later edge.
  assign pop  = ~VidReq & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (VidReq)   state_d = ST_READ;
    else if (pop) state_d = ST_WRITE;
    else          state_d = ST_IDLE;
    wr_ready_d = (cnt_d != CW'(FIFO_DEPTH));
    // After this edge a read is in flight if one issues now or one issued
    // last edge and has not returned yet.
    idle_d = (cnt_d == '0) && !VidReq && !vld_pipe_q[0] && (state_d == ST_IDLE);
  end

  // Buffer storage needs no reset: occupancy lives in the pointers.
  always_ff @(posedge Clock50) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= WrAddr;
      fifo_data_q[wr_ptr_q] <= WrData;
    end
  end

  always_ff @(posedge Clock50 or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      VidValid   <= 1'b0;
      VidData    <= '0;
      WrReady    <= 1'b1;
      WrOverflow <= 1'b0;
      MemAddr    <= '0;
      MemWe      <= 1'b0;
      MemWData   <= '0;
      Idle       <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      WrReady <= wr_ready_d;
      Idle    <= idle_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (WrReq && !WrReady) WrOverflow <= 1'b1;

      vld_pipe_q <= {vld_pipe_q[0], VidReq};
      VidValid   <= vld_pipe_q[1];
      if (vld_pipe_q[1]) VidData <= MemRData;

      case (state_d)
        ST_READ: begin
          MemAddr <= VidAddr;
          MemWe   <= 1'b0;
        end
        ST_WRITE: begin
          MemAddr  <= fifo_addr_q[rd_ptr_q];
          MemWData <= fifo_data_q[rd_ptr_q];
          MemWe    <= 1'b1;
        end
        default: MemWe <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          Clock50 = 1'b0;
  logic          Reset   = 1'b1;
  logic          VidReq  = 1'b0;
  logic [AW-1:0] VidAddr = '0;
  logic          VidValid;
  logic [DW-1:0] VidData;
  logic          WrReq   = 1'b0;
  logic [AW-1:0] WrAddr  = '0;
  logic [DW-1:0] WrData  = '0;
  logic          WrReady;
  logic          WrOverflow;
  logic [AW-1:0] MemAddr;
  logic          MemWe;
  logic [DW-1:0] MemWData;
  logic [DW-1:0] MemRData = '0;
  logic          Idle;

  int total = 0;
  int bad   = 0;

  vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(4)) dut (
    .Clock50(Clock50), .Reset(Reset),
    .VidReq(VidReq), .VidAddr(VidAddr), .VidValid(VidValid), .VidData(VidData),
    .WrReq(WrReq), .WrAddr(WrAddr), .WrData(WrData),
    .WrReady(WrReady), .WrOverflow(WrOverflow),
    .MemAddr(MemAddr), .MemWe(MemWe), .MemWData(MemWData), .MemRData(MemRData),
    .Idle(Idle)
  );

  always #5 Clock50 = ~Clock50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge Clock50);
    #1;
  endtask

  initial begin
    // ---- reset state, no clock edge required
    #2 Reset = 1'b0;
    #1;
    chk("rst_vidvalid", VidValid, 0);
    chk("rst_memwe", MemWe, 0);
    chk("rst_ovf", WrOverflow, 0);
    chk("rst_memaddr", MemAddr, 0);
    chk("rst_wdata", MemWData, 0);
    chk("rst_viddata", VidData, 0);
    chk("rst_wrready", WrReady, 1);
    chk("rst_idle", Idle, 1);
    tick(); tick();
    Reset = 1'b1;

    // ---- single write
    WrReq = 1; WrAddr = 18'h00010; WrData = 16'hABCD;
    tick();
    WrReq = 0;
    chk("sw_idle0", Idle, 0);
    chk("sw_we0", MemWe, 0);
    tick();
    chk("sw_we", MemWe, 1);
    chk("sw_addr", MemAddr, 18'h00010);
    chk("sw_data", MemWData, 16'hABCD);
    chk("sw_idle_busy", Idle, 0);
    tick();
    chk("sw_we_off", MemWe, 0);
    chk("sw_idle1", Idle, 1);
    chk("sw_addr_hold", MemAddr, 18'h00010);

    // ---- read latency
    VidReq = 1; VidAddr = 18'h00100;
    tick();
    VidReq = 0;
    chk("rl_addr", MemAddr, 18'h00100);
    chk("rl_we", MemWe, 0);
    chk("rl_v0", VidValid, 0);
    MemRData = 16'h1234;
    tick();
    chk("rl_v1", VidValid, 0);
    tick();
    chk("rl_v2", VidValid, 1);
    chk("rl_data", VidData, 16'h1234);
    tick();
    chk("rl_v3", VidValid, 0);

    // ---- back-to-back reads
    VidReq = 1; VidAddr = 18'h00001;
    tick();
    VidAddr = 18'h00002;
    tick();
    chk("bb_addr", MemAddr, 18'h00002);
    MemRData = 16'h1111; VidAddr = 18'h00003;
    tick();
    chk("bb_v0", VidValid, 1);
    chk("bb_d0", VidData, 16'h1111);
    MemRData = 16'h2222; VidReq = 0;
    tick();
    chk("bb_v1", VidValid, 1);
    chk("bb_d1", VidData, 16'h2222);
    MemRData = 16'h3333;
    tick();
    chk("bb_v2", VidValid, 1);
    chk("bb_d2", VidData, 16'h3333);
    tick();
    chk("bb_v3", VidValid, 0);

    // ---- priority: two buffered writes interleaved with alternate reads
    MemRData = 16'h5A5A;
    VidReq = 1; VidAddr = 18'h00200; WrReq = 1; WrAddr = 18'h00020; WrData = 16'hAAAA;
    tick();
    VidAddr = 18'h00201; WrAddr = 18'h00021; WrData = 16'hBBBB;
    tick();
    WrReq = 0; VidReq = 0;
    chk("pr_read_we", MemWe, 0);
    chk("pr_read_addr", MemAddr, 18'h00201);
    tick();
    chk("pr_w0_we", MemWe, 1);
    chk("pr_w0_addr", MemAddr, 18'h00020);
    chk("pr_w0_data", MemWData, 16'hAAAA);
    chk("pr_vv0", VidValid, 1);
    chk("pr_vd0", VidData, 16'h5A5A);
    VidReq = 1; VidAddr = 18'h00300;
    tick();
    VidReq = 0;
    chk("pr_r1_we", MemWe, 0);
    chk("pr_r1_addr", MemAddr, 18'h00300);
    tick();
    chk("pr_w1_we", MemWe, 1);
    chk("pr_w1_addr", MemAddr, 18'h00021);
    chk("pr_w1_data", MemWData, 16'hBBBB);
    VidReq = 1; VidAddr = 18'h00301;
    tick();
    VidReq = 0;
    chk("pr_r2_we", MemWe, 0);
    chk("pr_r2_vv", VidValid, 1);
    tick();
    chk("pr_idle_we", MemWe, 0);
    chk("pr_idle_addr", MemAddr, 18'h00301);
    tick();
    chk("pr_last_vv", VidValid, 1);
    tick();
    chk("pr_idle", Idle, 1);

    // ---- full / overflow with reads hogging the memory
    VidReq = 1; VidAddr = 18'h00400; WrReq = 1;
    for (int i = 0; i < 5; i++) begin
      WrAddr = AW'(18'h00040 + i);
      WrData = DW'(16'h00D0 + i);
      tick();
      chk($sformatf("fu_ready%0d", i), WrReady, (i < 3) ? 1 : 0);
      chk($sformatf("fu_ovf%0d", i), WrOverflow, (i == 4) ? 1 : 0);
      chk($sformatf("fu_we%0d", i), MemWe, 0);
    end
    VidReq = 0; WrReq = 0;
    for (int d = 0; d < 4; d++) begin
      tick();
      chk($sformatf("dr_we%0d", d), MemWe, 1);
      chk($sformatf("dr_addr%0d", d), MemAddr, 18'h00040 + d);
      chk($sformatf("dr_data%0d", d), MemWData, 16'h00D0 + d);
      chk($sformatf("dr_ready%0d", d), WrReady, 1);
    end
    tick();
    chk("dr_we_end", MemWe, 0);
    chk("dr_idle", Idle, 1);
    chk("dr_ovf_sticky", WrOverflow, 1);

    // ---- reset mid-operation
    VidReq = 1; VidAddr = 18'h00500; WrReq = 1;
    for (int i = 0; i < 3; i++) begin
      WrAddr = AW'(18'h00050 + i);
      WrData = DW'(16'h00E0 + i);
      tick();
    end
    VidReq = 0; WrReq = 0;
    chk("mr_busy", Idle, 0);
    #2 Reset = 1'b0;
    #1;
    chk("mr_idle", Idle, 1);
    chk("mr_ready", WrReady, 1);
    chk("mr_ovf", WrOverflow, 0);
    chk("mr_we", MemWe, 0);
    tick();
    Reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("mr_post_we%0d", k), MemWe, 0);
      chk($sformatf("mr_post_vv%0d", k), VidValid, 0);
      chk($sformatf("mr_post_idle%0d", k), Idle, 1);
    end

    // ---- first edges after reset arbitrate normally
    VidReq = 1; VidAddr = 18'h00777; MemRData = 16'h0F0F;
    tick();
    VidReq = 0;
    chk("ar_addr", MemAddr, 18'h00777);
    tick();
    tick();
    chk("ar_vv", VidValid, 1);
    chk("ar_vd", VidData, 16'h0F0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
